// File: rtl/apac_keypad_tx_pkg.sv
// ---------------------------------------------------------------------------
// apac_keypad_tx_pkg
// Shared definitions for the keypad-side password transmitter and the parking
// controller: key codes, FSM state encoding, default parameter values and small
// helper functions.
// ---------------------------------------------------------------------------
package apac_keypad_tx_pkg;

   // Special key codes; 0x0-0x9 are digits, anything above 0xB is ignored.
   localparam logic [3:0] KeyEnter = 4'hA;
   localparam logic [3:0] KeyClear = 4'hB;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StCollect  = 3'd1,
      StSend     = 3'd2,
      StWaitResp = 3'd3,
      StLocked   = 3'd4
   } state_e;

   // Defaults shared with the controller side.
   localparam int unsigned DefDigits     = 2;
   localparam int unsigned DefDigitW     = 4;
   localparam int unsigned DefPwW        = DefDigits * DefDigitW;
   localparam int unsigned DefTimeoutCyc = 1000;
   localparam int unsigned DefRespCyc    = 64;
   localparam int unsigned DefMaxTries   = 3;
   localparam int unsigned DefLockCyc    = 4096;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/apac_cycle_timer.sv
// ---------------------------------------------------------------------------
// apac_cycle_timer
// Loadable down-counter shared by the entry timeout, the response timeout and
// the lockout period. Saturates at zero (never wraps).
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset (counter -> 0)
//   load_i      load load_val_i this cycle (has priority over count_i)
//   load_val_i  value to load
//   count_i     decrement by one this cycle (stops at zero)
//   done_o      counter is zero
// ---------------------------------------------------------------------------
module apac_cycle_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             count_i,
   output logic             done_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/apac_keypad_tx.sv
// ---------------------------------------------------------------------------
// apac_keypad_tx
// Keypad-side transmitter for the parking controller's password interface.
// Collects BCD digits into a packed attempt, strobes try_psswrd for one cycle,
// waits for the open_gate/alarm_1 verdict, and enforces an entry timeout, a
// response timeout and a lockout after MAX_TRIES consecutive rejections.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   key_valid     one-cycle strobe qualifying key_code
//   key_code      0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, others ignored
//   open_gate     controller accepted the attempt
//   alarm_1       controller rejected the attempt
//   try_psswrd    one-cycle attempt strobe (registered)
//   psswrd_atmpt  packed attempt, first digit in the MS nibble (registered)
//   digit_cnt     digits currently held (registered)
//   busy          high in COLLECT/SEND/WAIT_RESP (registered)
//   lockout       high in LOCKED (registered)
// ---------------------------------------------------------------------------
module apac_keypad_tx
   import apac_keypad_tx_pkg::*;
#(
   parameter int unsigned DIGITS      = DefDigits,
   parameter int unsigned DIGIT_W     = DefDigitW,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
   parameter int unsigned RESP_CYC    = DefRespCyc,
   parameter int unsigned MAX_TRIES   = DefMaxTries,
   parameter int unsigned LOCK_CYC    = DefLockCyc
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              key_valid,
   input  logic [3:0]                        key_code,
   input  logic                              open_gate,
   input  logic                              alarm_1,
   output logic                              try_psswrd,
   output logic [DIGITS*DIGIT_W-1:0]         psswrd_atmpt,
   output logic [$clog2(DIGITS+1)-1:0]       digit_cnt,
   output logic                              busy,
   output logic                              lockout
);

   localparam int unsigned PW_W   = DIGITS * DIGIT_W;
   localparam int unsigned CntW   = $clog2(DIGITS + 1);
   localparam int unsigned RejW   = $clog2(MAX_TRIES + 1);
   localparam int unsigned TimerW = $clog2(max3(TIMEOUT_CYC, RESP_CYC, LOCK_CYC) + 1);

   // The timer expires when it has been zero for a full cycle, so loading N-1
   // gives exactly N cycles in the state before the exit transition.
   localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYC - 1);
   localparam logic [TimerW-1:0] RespLoad    = TimerW'(RESP_CYC - 1);
   localparam logic [TimerW-1:0] LockLoad    = TimerW'(LOCK_CYC - 1);

   state_e            state_d, state_q;
   logic [PW_W-1:0]   buf_d, buf_q;
   logic [PW_W-1:0]   atmpt_d, atmpt_q;
   logic [CntW-1:0]   cnt_d, cnt_q;
   logic [RejW-1:0]   rej_d, rej_q;
   logic              try_d, try_q;
   logic              busy_d, busy_q;
   logic              lockout_d, lockout_q;

   logic              tmr_load;
   logic [TimerW-1:0] tmr_val;
   logic              tmr_count;
   logic              tmr_done;

   logic              key_digit;
   logic [RejW-1:0]   rej_inc;

   assign key_digit = is_digit(key_code);
   assign rej_inc   = rej_q + RejW'(1);

   apac_cycle_timer #(
      .Width (TimerW)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .count_i    (tmr_count),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      atmpt_d   = atmpt_q;
      cnt_d     = cnt_q;
      rej_d     = rej_q;
      try_d     = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_count = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (key_valid && key_digit) begin
               buf_d    = PW_W'(key_code);
               cnt_d    = CntW'(1);
               state_d  = StCollect;
               tmr_load = 1'b1;
               tmr_val  = TimeoutLoad;
            end
         end

         StCollect: begin
            if (key_valid) begin
               // Any key, even an ignored one, restarts the entry timeout and
               // takes precedence over an expiry in the same cycle.
               tmr_load = 1'b1;
               tmr_val  = TimeoutLoad;
               if (key_digit) begin
                  if (cnt_q < CntW'(DIGITS)) begin
                     buf_d = (buf_q << DIGIT_W) | PW_W'(key_code);
                     cnt_d = cnt_q + CntW'(1);
                  end
               end else if (key_code == KeyClear) begin
                  buf_d   = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end else if (key_code == KeyEnter) begin
                  if (cnt_q == CntW'(DIGITS)) begin
                     atmpt_d = buf_q;
                     try_d   = 1'b1;
                     state_d = StSend;
                  end else begin
                     buf_d   = '0;
                     cnt_d   = '0;
                     state_d = StIdle;
                  end
               end
            end else if (tmr_done) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               tmr_count = 1'b1;
            end
         end

         StSend: begin
            // try_psswrd was registered on entry; it drops on the way out.
            state_d  = StWaitResp;
            tmr_load = 1'b1;
            tmr_val  = RespLoad;
         end

         StWaitResp: begin
            if (open_gate) begin
               rej_d   = '0;
               buf_d   = '0;
               atmpt_d = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else if (alarm_1) begin
               buf_d   = '0;
               atmpt_d = '0;
               cnt_d   = '0;
               if (rej_inc == RejW'(MAX_TRIES)) begin
                  rej_d    = '0;
                  state_d  = StLocked;
                  tmr_load = 1'b1;
                  tmr_val  = LockLoad;
               end else begin
                  rej_d   = rej_inc;
                  state_d = StIdle;
               end
            end else if (tmr_done) begin
               buf_d   = '0;
               atmpt_d = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               tmr_count = 1'b1;
            end
         end

         StLocked: begin
            buf_d = '0;
            cnt_d = '0;
            if (tmr_done) begin
               state_d = StIdle;
            end else begin
               tmr_count = 1'b1;
            end
         end

         default: begin
            buf_d   = '0;
            atmpt_d = '0;
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase

      // Status outputs follow the next state so they are registered and
      // aligned with the state they describe.
      busy_d    = (state_d == StCollect) || (state_d == StSend) || (state_d == StWaitResp);
      lockout_d = (state_d == StLocked);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         buf_q     <= '0;
         atmpt_q   <= '0;
         cnt_q     <= '0;
         rej_q     <= '0;
         try_q     <= 1'b0;
         busy_q    <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         atmpt_q   <= atmpt_d;
         cnt_q     <= cnt_d;
         rej_q     <= rej_d;
         try_q     <= try_d;
         busy_q    <= busy_d;
         lockout_q <= lockout_d;
      end
   end

   assign try_psswrd   = try_q;
   assign psswrd_atmpt = atmpt_q;
   assign digit_cnt    = cnt_q;
   assign busy         = busy_q;
   assign lockout      = lockout_q;

endmodule

// File: tb/tb_apac_keypad_tx.sv
// ---------------------------------------------------------------------------
// tb_apac_keypad_tx
// Directed self-checking bench for apac_keypad_tx with DIGITS=2,
// TIMEOUT_CYC=20, RESP_CYC=10, MAX_TRIES=3, LOCK_CYC=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_apac_keypad_tx;

   localparam logic [3:0] KEnter = 4'hA;
   localparam logic [3:0] KClear = 4'hB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'hF;
   logic       open_gate = 1'b0;
   logic       alarm_1 = 1'b0;
   logic       try_psswrd;
   logic [7:0] psswrd_atmpt;
   logic [1:0] digit_cnt;
   logic       busy;
   logic       lockout;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;
   int try_cnt  = 0;
   int t0;

   apac_keypad_tx #(
      .DIGITS      (2),
      .DIGIT_W     (4),
      .TIMEOUT_CYC (20),
      .RESP_CYC    (10),
      .MAX_TRIES   (3),
      .LOCK_CYC    (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .open_gate    (open_gate),
      .alarm_1      (alarm_1),
      .try_psswrd   (try_psswrd),
      .psswrd_atmpt (psswrd_atmpt),
      .digit_cnt    (digit_cnt),
      .busy         (busy),
      .lockout      (lockout)
   );

   always #5 clk = ~clk;

   // Strobe counter sampled mid-cycle.
   always @(negedge clk) begin
      if (try_psswrd === 1'b1) try_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      step();
      key_valid = 1'b0;
      key_code  = 4'hF;
   endtask

   // Two digits then ENTER; returns with the DUT in SEND.
   task automatic enter2(input logic [3:0] a, input logic [3:0] b);
      press(a);
      press(b);
      press(KEnter);
   endtask

   task automatic respond(input logic og, input logic al);
      open_gate = og;
      alarm_1   = al;
      step();
      open_gate = 1'b0;
      alarm_1   = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".try"}, 32'(try_psswrd), 32'd0);
      chk({tag, ".atmpt"}, 32'(psswrd_atmpt), 32'd0);
      chk({tag, ".cnt"}, 32'(digit_cnt), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".lock"}, 32'(lockout), 32'd0);
   endtask

   initial begin
      // Reset
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // 1: 4,2,ENTER, accept 3 cycles after the strobe
      t0 = try_cnt;
      press(4'd4);
      chk("t1.cnt1", 32'(digit_cnt), 32'd1);
      chk("t1.busy", 32'(busy), 32'd1);
      press(4'd2);
      chk("t1.cnt2", 32'(digit_cnt), 32'd2);
      press(KEnter);
      chk("t1.try_hi", 32'(try_psswrd), 32'd1);
      chk("t1.atmpt_send", 32'(psswrd_atmpt), 32'h42);
      step();
      chk("t1.try_lo", 32'(try_psswrd), 32'd0);
      chk("t1.atmpt_wait", 32'(psswrd_atmpt), 32'h42);
      step();
      step();
      chk("t1.atmpt_hold", 32'(psswrd_atmpt), 32'h42);
      chk("t1.busy_wait", 32'(busy), 32'd1);
      respond(1'b1, 1'b0);
      chk("t1.atmpt_clr", 32'(psswrd_atmpt), 32'h0);
      chk("t1.cnt0", 32'(digit_cnt), 32'd0);
      chk("t1.idle", 32'(busy), 32'd0);
      chk("t1.pulses", 32'(try_cnt - t0), 32'd1);

      // 2: third digit ignored; short entry discarded
      press(4'd1);
      press(4'd2);
      press(4'd3);
      chk("t2.cnt_sat", 32'(digit_cnt), 32'd2);
      press(KEnter);
      chk("t2.atmpt", 32'(psswrd_atmpt), 32'h12);
      step();
      respond(1'b1, 1'b0);
      t0 = try_cnt;
      press(4'd7);
      chk("t2.cnt1", 32'(digit_cnt), 32'd1);
      press(KEnter);
      step();
      chk("t2.short_cnt", 32'(digit_cnt), 32'd0);
      chk("t2.short_busy", 32'(busy), 32'd0);
      chk("t2.no_try", 32'(try_cnt - t0), 32'd0);

      // 3: CLEAR, short entry, timeout boundary
      t0 = try_cnt;
      press(4'd5);
      press(KClear);
      chk("t3.clr_cnt", 32'(digit_cnt), 32'd0);
      chk("t3.clr_busy", 32'(busy), 32'd0);
      press(4'd6);
      press(KEnter);
      step();
      chk("t3.no_try", 32'(try_cnt - t0), 32'd0);
      chk("t3.short_cnt", 32'(digit_cnt), 32'd0);
      // Key in the expiry cycle wins over the timeout
      press(4'd9);
      repeat (19) step();
      chk("t3.pre_exp", 32'(busy), 32'd1);
      press(4'd8);
      chk("t3.key_wins_cnt", 32'(digit_cnt), 32'd2);
      chk("t3.key_wins_busy", 32'(busy), 32'd1);
      press(KClear);
      press(4'd9);
      repeat (19) step();
      chk("t3.busy_19", 32'(busy), 32'd1);
      step();
      chk("t3.to_cnt", 32'(digit_cnt), 32'd0);
      chk("t3.to_busy", 32'(busy), 32'd0);

      // 4: three rejections -> lockout for 16 cycles
      enter2(4'd1, 4'd1);
      step();
      respond(1'b0, 1'b1);
      chk("t4.rej1_lock", 32'(lockout), 32'd0);
      enter2(4'd2, 4'd2);
      step();
      respond(1'b0, 1'b1);
      chk("t4.rej2_lock", 32'(lockout), 32'd0);
      enter2(4'd3, 4'd3);
      step();
      respond(1'b0, 1'b1);
      chk("t4.rej3_lock", 32'(lockout), 32'd1);
      chk("t4.rej3_busy", 32'(busy), 32'd0);
      chk("t4.rej3_atmpt", 32'(psswrd_atmpt), 32'h0);
      t0 = try_cnt;
      press(4'd1);
      press(4'd2);
      press(KEnter);
      chk("t4.lk_cnt", 32'(digit_cnt), 32'd0);
      repeat (12) step();
      chk("t4.lk_no_try", 32'(try_cnt - t0), 32'd0);
      chk("t4.lk_15", 32'(lockout), 32'd1);
      step();
      chk("t4.lk_16", 32'(lockout), 32'd0);
      enter2(4'd3, 4'd4);
      chk("t4.post_try", 32'(try_psswrd), 32'd1);
      chk("t4.post_atmpt", 32'(psswrd_atmpt), 32'h34);
      step();
      respond(1'b1, 1'b0);

      // 5: simultaneous verdict is an accept; response timeout keeps count
      enter2(4'd1, 4'd0);
      step();
      respond(1'b0, 1'b1);
      enter2(4'd2, 4'd0);
      step();
      respond(1'b0, 1'b1);
      chk("t5.two_rej", 32'(lockout), 32'd0);
      enter2(4'd5, 4'd6);
      step();
      respond(1'b1, 1'b1);
      chk("t5.both_lock", 32'(lockout), 32'd0);
      chk("t5.both_busy", 32'(busy), 32'd0);
      chk("t5.both_atmpt", 32'(psswrd_atmpt), 32'h0);
      enter2(4'd5, 4'd7);
      step();
      respond(1'b0, 1'b1);
      chk("t5.after_clr", 32'(lockout), 32'd0);
      enter2(4'd5, 4'd8);
      repeat (10) step();
      chk("t5.resp_9", 32'(busy), 32'd1);
      chk("t5.resp_atmpt", 32'(psswrd_atmpt), 32'h58);
      step();
      chk("t5.resp_to_busy", 32'(busy), 32'd0);
      chk("t5.resp_to_atmpt", 32'(psswrd_atmpt), 32'h0);
      chk("t5.resp_to_lock", 32'(lockout), 32'd0);
      enter2(4'd5, 4'd9);
      step();
      respond(1'b0, 1'b1);
      chk("t5.count_kept", 32'(lockout), 32'd0);

      // 6: asynchronous reset in COLLECT and in WAIT_RESP
      press(4'd7);
      chk("t6.collect", 32'(digit_cnt), 32'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("t6.rst_collect");
      step();
      rst = 1'b0;
      enter2(4'd8, 4'd9);
      step();
      chk("t6.wait_atmpt", 32'(psswrd_atmpt), 32'h89);
      rst = 1'b1;
      #1;
      chk_all_zero("t6.rst_wait");
      step();
      rst = 1'b0;
      press(4'd1);
      chk("t6.idle_after", 32'(digit_cnt), 32'd1);
      press(4'd2);
      press(KEnter);
      step();
      respond(1'b0, 1'b1);
      chk("t6.rej_cleared", 32'(lockout), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
